riscv_pipe_stage: RTL and testbench
===================================

// Module: riscv_pipe_stage
// PURPOSE
//  Generic parametrised pipeline-stage register for the RISC-V core (IF/ID, ID/EX, EX/MEM).
//  Replaces hand-written stall/flush register banks with a valid/ready handshake.
//  Payload is split in two parts:
//   - CTRL: flushable, zeroed on kill, so a zero ctrl word is a NOP.
//   - DATA: not flushable (operands, imm, pc, pred_dest).
//  Adds saturating stall/flush/bubble performance counters.
// PARAMETERS
//  DATA_W  128  width of non-flushable payload (rs1/rs2 data, imm, pc, pred_dest)
//  CTRL_W   24  width of flushable control payload (rd, rs1, rs2, alu op, mem/jump/mul flags)
//  CNT_W    32  width of each performance counter
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       reset, synchronous, active-low
//  flush       in   1       kill all held beats and the inbound beat this cycle
//  in_valid    in   1       upstream beat valid
//  in_ready    out  1       stage can accept a beat
//  in_ctrl     in   CTRL_W  upstream control payload
//  in_data     in   DATA_W  upstream data payload
//  out_valid   out  1       downstream beat valid
//  out_ready   in   1       downstream accepts (replaces legacy !stall)
//  out_ctrl    out  CTRL_W  registered control; all-zero whenever out_valid=0
//  out_data    out  DATA_W  registered data; holds last value when out_valid=0
//  stall_cnt   out  CNT_W   cycles with out_valid & !out_ready
//  flush_cnt   out  CNT_W   cycles with flush while at least one beat is held
//  bubble_cnt  out  CNT_W   cycles with out_ready & !out_valid
// BEHAVIOUR
//  Reset: out_valid=0, out_ctrl=0, out_data=0, all counters=0, skid empty.
//   - in_ready is combinational after reset, so its reset-cycle value is not specified.
//  Transfers: an upstream beat moves when in_valid & in_ready. A downstream beat moves when out_valid & out_ready.
//  Latency: 1 cycle from an accepted input to out_valid.
//  Base mode (no skid):
//   - in_ready = !out_valid | out_ready. This is a combinational path from out_ready.
//   - Pass-through rate: 1 beat per cycle.
//  Main register update:
//   - Loads a new beat on accept.
//   - If the held beat leaves and nothing enters: out_valid<=0 and out_ctrl<=0; out_data is held.
//   - If stalled (out_valid & !out_ready): all outputs are held stable. Required, as the regfile read is not re-issued.
//  Flush (highest priority):
//   - Next cycle: out_valid=0, out_ctrl=0, skid emptied.
//   - The inbound beat in the flush cycle is dropped even if in_valid & in_ready.
//   - out_data still loads in_data on that cycle, if in_valid.
//  Simultaneous flush + rst_n=0: reset wins, with identical result except out_data=0.
//  Reset during a stall: held beat is discarded; no beat is presented after reset.
//  Counters:
//   - Each saturates at 2^CNT_W-1 and never wraps.
//   - Each increments at most once per cycle.
//   - During reset, counters are cleared and do not count.
//  Ordering: beats leave in acceptance order. No duplication, no loss except on flush.
// CONFIGURATION
//  Macro PIPE_SKID_EN:
//   - Defined: adds a 1-entry skid buffer (total capacity 2).
//   - in_ready = !skid_valid, taken directly from a flop. This cuts the out_ready->in_ready path.
//   - When main is full and stalled, an accepted beat goes to skid.
//   - On the next out_ready, main loads from skid (before any new input) and skid empties.
//   - Flush empties both main and skid. Full-rate throughput is kept.
//  Not defined: base mode only; no skid flops are synthesised.
// STRUCTURE
//  Package riscv_pipe_pkg:
//   - ctrl field widths/offsets (RD, RS1, RS2, ALU_OP, flag bits)
//   - localparam CTRL_NOP='0
//   - typedefs for ctrl/data words shared by decoder and EX stage
//  Sub-module riscv_sat_counter (CNT_W, inc, clear) instanced 3x for the counters.
// TESTING
//  1. Reset, then stream 8 beats with out_ready=1:
//     - out_valid rises 1 cycle after each accept.
//     - data/ctrl match in order.
//     - bubble_cnt=1 (the first cycle only).
//  2. Beat A held, out_ready=0 for 5 cycles:
//     - out_ctrl/out_data are stable.
//     - stall_cnt=5.
//     - base mode: in_ready=0.
//     - skid mode: B is accepted, then in_ready=0; A then B emerge after out_ready=1.
//  3. flush with A held and B inbound:
//     - next cycle out_valid=0, out_ctrl=0.
//     - B never appears.
//     - flush_cnt=1.
//  4. flush with stage empty: flush_cnt unchanged, out_ctrl stays 0.
//  5. rst_n=0 mid-stall with a beat held (and skid full): next cycle out_valid=0, all counters=0.
//  6. CNT_W=4, hold a stall for 20 cycles: stall_cnt saturates at 15 and stays 15.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Package: riscv_pipe_pkg
// Shared definitions for the pipeline-stage registers of the RISC-V core.
// - Field layout of the flushable control word (rd, rs1, rs2, alu op, flags).
// - Default payload widths, and typedefs for the ctrl/data words passed
//   between the decoder and the EX stage.
// - CTRL_NOP: the all-zero control word. Any stage treats it as a bubble.
package riscv_pipe_pkg;

    localparam int CTRL_W_DEF = 24;
    localparam int DATA_W_DEF = 128;

    // Control word field layout, LSB first.
    localparam int RD_LSB      = 0;
    localparam int RD_W        = 5;
    localparam int RS1_LSB     = 5;
    localparam int RS1_W       = 5;
    localparam int RS2_LSB     = 10;
    localparam int RS2_W       = 5;
    localparam int ALU_OP_LSB  = 15;
    localparam int ALU_OP_W    = 4;
    localparam int FLAG_MEM_RD = 19;
    localparam int FLAG_MEM_WR = 20;
    localparam int FLAG_JUMP   = 21;
    localparam int FLAG_BRANCH = 22;
    localparam int FLAG_MUL    = 23;

    typedef logic [CTRL_W_DEF-1:0] ctrl_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/riscv_sat_counter.sv
// Module: riscv_sat_counter
// Saturating up-counter used for the pipeline performance statistics.
// Ports:
//   clk    in   1      clock
//   clear  in   1      synchronous clear; takes priority over inc
//   inc    in   1      add one this cycle, unless already at all-ones
//   count  out  CNT_W  current count; sticks at 2^CNT_W-1
module riscv_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/riscv_pipe_stage.sv
// Module: riscv_pipe_stage
// Generic valid/ready pipeline register for the IF/ID, ID/EX and EX/MEM stages.
// The payload has two parts. The control word is zeroed on flush or when the
// stage empties, so a zero word is a NOP. The data word is only ever
// overwritten, never cleared.
// Optional macro PIPE_SKID_EN adds a one-entry skid buffer. With it, in_ready
// comes straight from a flop, which breaks the out_ready->in_ready path.
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   flush                 kill the held beat(s) and this cycle's inbound beat
//   in_valid/in_ready     upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready   downstream handshake, out_ctrl/out_data payload
//   stall_cnt             cycles with out_valid & !out_ready
//   flush_cnt             cycles with flush while a beat is held
//   bubble_cnt            cycles with out_ready & !out_valid
module riscv_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

    logic              valid_reg, valid_next;
    logic [CTRL_W-1:0] ctrl_reg,  ctrl_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic              accept;
    logic              main_free;   // main register may take a beat this cycle
    logic              held;        // at least one beat inside the stage

    assign main_free = !valid_reg || out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid_reg, skid_valid_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;

    assign in_ready = !skid_valid_reg;
    assign held     = valid_reg || skid_valid_reg;
`else
    assign in_ready = main_free;
    assign held     = valid_reg;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        valid_next = valid_reg;
        ctrl_next  = ctrl_reg;
        data_next  = data_reg;
`ifdef PIPE_SKID_EN
        skid_valid_next = skid_valid_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        skid_data_next  = skid_data_reg;
`endif
        if (flush) begin
            // The inbound data is still captured. Only the control word
            // decides whether a beat is live.
            valid_next = 1'b0;
            ctrl_next  = NOP;
            if (in_valid) begin
                data_next = in_data;
            end
`ifdef PIPE_SKID_EN
            skid_valid_next = 1'b0;
`endif
        end else begin
`ifdef PIPE_SKID_EN
            if (main_free) begin
                // The skid beat is older than anything inbound, so it goes
                // first. While the skid is full, in_ready is low.
                if (skid_valid_reg) begin
                    valid_next      = 1'b1;
                    ctrl_next       = skid_ctrl_reg;
                    data_next       = skid_data_reg;
                    skid_valid_next = 1'b0;
                end else if (accept) begin
                    valid_next = 1'b1;
                    ctrl_next  = in_ctrl;
                    data_next  = in_data;
                end else begin
                    valid_next = 1'b0;
                    ctrl_next  = NOP;
                end
            end else if (accept) begin
                skid_valid_next = 1'b1;
                skid_ctrl_next  = in_ctrl;
                skid_data_next  = in_data;
            end
`else
            if (accept) begin
                valid_next = 1'b1;
                ctrl_next  = in_ctrl;
                data_next  = in_data;
            end else if (main_free) begin
                valid_next = 1'b0;
                ctrl_next  = NOP;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= NOP;
            data_reg  <= '0;
`ifdef PIPE_SKID_EN
            skid_valid_reg <= 1'b0;
            skid_ctrl_reg  <= NOP;
            skid_data_reg  <= '0;
`endif
        end else begin
            valid_reg <= valid_next;
            ctrl_reg  <= ctrl_next;
            data_reg  <= data_next;
`ifdef PIPE_SKID_EN
            skid_valid_reg <= skid_valid_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            skid_data_reg  <= skid_data_next;
`endif
        end
    end

    assign out_valid = valid_reg;
    assign out_ctrl  = ctrl_reg;
    assign out_data  = data_reg;

    // Counter order: 0 = stall, 1 = flush, 2 = bubble.
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];
    logic             cnt_clear;

    assign cnt_clear  = !rst_n;
    assign cnt_inc[0] = valid_reg && !out_ready;
    assign cnt_inc[1] = flush && held;
    assign cnt_inc[2] = out_ready && !valid_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            riscv_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .clear (cnt_clear),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt  = cnt_val[0];
    assign flush_cnt  = cnt_val[1];
    assign bubble_cnt = cnt_val[2];

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Testbench for riscv_pipe_stage. A scoreboard queue holds the beats the
// stage should contain. A negedge monitor checks the output beat and in_ready
// against that queue. Scenario tasks check counters, stability and flush/reset
// behaviour inline. A second instance with CNT_W=4 exercises saturation.
// Honours PIPE_SKID_EN in the same way as the RTL.
module tb_riscv_pipe_stage;

    localparam int DW = 128;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [31:0]   stall_cnt, flush_cnt, bubble_cnt;

    logic          in_ready4, out_valid4;
    logic [CW-1:0] out_ctrl4;
    logic [DW-1:0] out_data4;
    logic [3:0]    stall_cnt4, flush_cnt4, bubble_cnt4;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;
    beat_t sb[$];

    always #5 clk = ~clk;

    riscv_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
    );

    riscv_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .bubble_cnt(bubble_cnt4)
    );

    // Scoreboard monitor. Inputs change 1 ns after posedge, so at the negedge
    // both the DUT outputs and the inputs for the coming edge are stable.
    always @(negedge clk) begin
        bit exp_valid;
        bit exp_rdy;
        if (mon_en) begin
            if (rst_n !== 1'b1) begin
                sb.delete();
            end else begin
                exp_valid = (sb.size() != 0);
`ifdef PIPE_SKID_EN
                exp_rdy = (sb.size() < 2);
`else
                exp_rdy = !exp_valid || out_ready;
`endif
                vectors++;
                if (out_valid !== exp_valid) begin
                    miscompares++;
                    $display("FAIL mon_out_valid t=%0t got %b exp %b", $time, out_valid, exp_valid);
                end
                if (exp_valid) begin
                    vectors++;
                    if (out_ctrl !== sb[0].c) begin
                        miscompares++;
                        $display("FAIL mon_out_ctrl t=%0t got %h exp %h", $time, out_ctrl, sb[0].c);
                    end
                    vectors++;
                    if (out_data !== sb[0].d) begin
                        miscompares++;
                        $display("FAIL mon_out_data t=%0t got %h exp %h", $time, out_data, sb[0].d);
                    end
                end else begin
                    vectors++;
                    if (out_ctrl !== '0) begin
                        miscompares++;
                        $display("FAIL mon_idle_ctrl t=%0t got %h exp 0", $time, out_ctrl);
                    end
                end
                vectors++;
                if (in_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL mon_in_ready t=%0t got %b exp %b", $time, in_ready, exp_rdy);
                end
                if (flush) begin
                    sb.delete();
                end else begin
                    if (exp_valid && out_ready) void'(sb.pop_front());
                    if (in_valid && exp_rdy) sb.push_back('{in_ctrl, in_data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        mon_en = 1'b1;
        rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = rnd_data(); in_ctrl = 24'hABCDEF;
        out_ready = 1'b0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b c=%h d=%h exp 0/0/0", out_valid, out_ctrl, out_data);
        end
        vectors++;
        if (stall_cnt !== 0 || flush_cnt !== 0 || bubble_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", stall_cnt, flush_cnt, bubble_cnt);
        end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic [CW-1:0] c [8];
        logic [DW-1:0] d [8];
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c[i] = 24'h800000 | CW'(i * 24'h010203 + 1);
            d[i] = rnd_data();
            in_ctrl = c[i]; in_data = d[i];
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_ctrl !== c[i]) begin
                miscompares++;
                $display("FAIL stream_beat%0d got v=%b c=%h exp 1/%h", i, out_valid, out_ctrl, c[i]);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (bubble_cnt !== 1) begin
            miscompares++;
            $display("FAIL stream_bubble_cnt got %0d exp 1", bubble_cnt);
        end
        vectors++;
        if (stall_cnt !== 0) begin
            miscompares++;
            $display("FAIL stream_stall_cnt got %0d exp 0", stall_cnt);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== d[7]) begin
            miscompares++;
            $display("FAIL stream_drain got v=%b c=%h d=%h exp 0/0/%h", out_valid, out_ctrl, out_data, d[7]);
        end
        $display("test_stream done");
    endtask

    task automatic test_stall();
        logic [CW-1:0] ca, cb;
        logic [DW-1:0] da, db;
        ca = 24'h9A0011; da = rnd_data();
        cb = 24'h450022; db = rnd_data();
        do_reset();
        in_valid = 1'b1; in_ctrl = ca; in_data = da;
        tick();
        in_ctrl = cb; in_data = db;
        for (int k = 1; k <= 5; k++) begin
            tick();
`ifdef PIPE_SKID_EN
            in_valid = 1'b0;
`else
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_in_ready k=%0d got %b exp 0", k, in_ready);
            end
`endif
            vectors++;
            if (out_valid !== 1'b1 || out_ctrl !== ca || out_data !== da) begin
                miscompares++;
                $display("FAIL stall_hold k=%0d got v=%b c=%h exp 1/%h", k, out_valid, out_ctrl, ca);
            end
        end
`ifdef PIPE_SKID_EN
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_skid_full got in_ready=%b exp 0", in_ready);
        end
`endif
        vectors++;
        if (stall_cnt !== 5) begin
            miscompares++;
            $display("FAIL stall_cnt got %0d exp 5", stall_cnt);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_ctrl !== cb || out_data !== db) begin
            miscompares++;
            $display("FAIL stall_next_beat got v=%b c=%h exp 1/%h", out_valid, out_ctrl, cb);
        end
        tick();
        tick();
        $display("test_stall done");
    endtask

    task automatic test_flush();
        logic [CW-1:0] ca, cb;
        logic [DW-1:0] da, db;
        ca = 24'h123456; da = rnd_data();
        cb = 24'h654321; db = rnd_data();
        do_reset();
        in_valid = 1'b1; in_ctrl = ca; in_data = da;
        tick();
        flush = 1'b1; out_ready = 1'b1; in_ctrl = cb; in_data = db;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            miscompares++;
            $display("FAIL flush_kill got v=%b c=%h exp 0/0", out_valid, out_ctrl);
        end
        vectors++;
        if (out_data !== db) begin
            miscompares++;
            $display("FAIL flush_data got %h exp %h", out_data, db);
        end
        vectors++;
        if (flush_cnt !== 1) begin
            miscompares++;
            $display("FAIL flush_cnt got %0d exp 1", flush_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_b k=%0d got v=%b exp 0", k, out_valid);
            end
        end
        $display("test_flush done");
    endtask

    task automatic test_flush_empty();
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
        tick();
        vectors++;
        if (flush_cnt !== 1 || out_ctrl !== '0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_empty got cnt=%0d c=%h v=%b exp 1/0/0", flush_cnt, out_ctrl, out_valid);
        end
        $display("test_flush_empty done");
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 24'h0F0F01; in_data = rnd_data();
        tick();
        in_ctrl = 24'h0F0F02; in_data = rnd_data();
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (stall_cnt !== 2) begin
            miscompares++;
            $display("FAIL rst_stall_pre got %0d exp 2", stall_cnt);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0 || bubble_cnt !== 0) begin
            miscompares++;
            $display("FAIL rst_stall got v=%b cnt=%0d/%0d/%0d exp 0 0/0/0",
                     out_valid, stall_cnt, flush_cnt, bubble_cnt);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || bubble_cnt !== 1 || stall_cnt !== 0) begin
            miscompares++;
            $display("FAIL rst_stall_after got v=%b bub=%0d stall=%0d exp 0/1/0",
                     out_valid, bubble_cnt, stall_cnt);
        end
        tick();
        $display("test_reset_stall done");
    endtask

    task automatic test_saturate();
        logic [CW-1:0] ca;
        logic [DW-1:0] da;
        logic [3:0]    exp4;
        ca = 24'h7E0042; da = rnd_data();
        do_reset();
        in_valid = 1'b1; in_ctrl = ca; in_data = da;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp4 = (k > 15) ? 4'd15 : 4'(k);
            vectors++;
            if (stall_cnt4 !== exp4) begin
                miscompares++;
                $display("FAIL sat_stall k=%0d got %0d exp %0d", k, stall_cnt4, exp4);
            end
        end
        vectors++;
        if (stall_cnt !== 20) begin
            miscompares++;
            $display("FAIL sat_wide_stall got %0d exp 20", stall_cnt);
        end
        vectors++;
        if (out_valid4 !== 1'b1 || out_ctrl4 !== ca || out_data4 !== da ||
            flush_cnt4 !== 0 || bubble_cnt4 !== 0) begin
            miscompares++;
            $display("FAIL sat_held got v=%b c=%h f=%0d b=%0d exp 1/%h/0/0",
                     out_valid4, out_ctrl4, flush_cnt4, bubble_cnt4, ca);
        end
        vectors++;
`ifdef PIPE_SKID_EN
        if (in_ready4 !== 1'b1) begin
`else
        if (in_ready4 !== 1'b0) begin
`endif
            miscompares++;
            $display("FAIL sat_in_ready got %b", in_ready4);
        end
        out_ready = 1'b1;
        tick();
        tick();
        $display("test_saturate done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_empty();
        test_reset_stall();
        test_saturate();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
